instr_loader: RTL and testbench

- Writes program words into instruction memory. The fetch path only reads that memory.
- Receives a little-endian byte stream: a 32-bit word count, then that many 32-bit instruction words.
- Assembles the bytes into words and issues one write per word at consecutive word-aligned byte addresses.
- Holds the core in reset until the load completes, then releases it so fetch starts at PC 0.

---
 rtl/instr_loader_pkg.sv | 32 +++
 rtl/instr_loader_word_assembler.sv | 54 +++++
 rtl/instr_loader.sv | 171 +++++++++++++++++
 tb/tb_instr_loader.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : instr_loader_pkg
//  Purpose  : Shared types and constants for the instruction loader.
//             Loader states, stream word geometry and a small helper used
//             to range-check the word count carried in the stream header.
//  Revision : 1.0 - initial release
// ============================================================================
package instr_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;

    typedef enum logic [1:0] {
        LEN  = 2'd0,
        DATA = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    // True when a header word count cannot fit in a memory of 2**addr_w words.
    // The count is compared as a 33-bit quantity so DEPTH itself is legal.
    function automatic logic count_exceeds(input logic [WORD_W-1:0] count,
                                           input int                addr_w);
        logic [WORD_W:0] depth;
        depth = '0;
        depth[addr_w] = 1'b1;
        return ({1'b0, count} > depth);
    endfunction

endpackage : instr_loader_pkg
`default_nettype wire

// File: rtl/instr_loader_word_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : word_assembler
//  Purpose  : Packs a little-endian byte stream into 32-bit words.
//             A 2-bit byte counter tracks the position inside the word and
//             a right-shifting register places the first byte at [7:0].
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             clear           - drop any partial word and restart at byte 0
//             byte_en         - accept byte_data this cycle
//             byte_data [7:0] - stream byte
//             word     [31:0] - assembled word (valid while word_valid=1)
//             word_valid      - one-cycle pulse in the cycle after the 4th byte
//  Revision : 1.0 - initial release
// ============================================================================
module word_assembler
    import instr_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [7:0]        byte_data,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    localparam logic [1:0] C_LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]        r_cnt;
    logic [WORD_W-1:0] r_shift;
    logic              r_valid;

    // New bytes enter at the top and move down, so after four bytes the
    // first one received sits in bits [7:0]. The counter wraps 3->0 on its
    // own, which starts the next word without extra logic.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt   <= 2'd0;
            r_shift <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= byte_en && (r_cnt == C_LAST_BYTE);
            if (byte_en) begin
                r_shift <= {byte_data, r_shift[WORD_W-1:8]};
                r_cnt   <= r_cnt + 2'd1;
            end
        end
    end

    assign word       = r_shift;
    assign word_valid = r_valid;

endmodule : word_assembler
`default_nettype wire

// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
//  Module   : instr_loader
//  Purpose  : Loads a program image from a byte stream into instruction
//             memory and holds the core in reset until the load completes.
//             Stream format (little-endian): 32-bit word count, then that
//             many 32-bit instruction words.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             byte_valid/byte_data- incoming stream byte
//             byte_ready          - loader accepts a byte this cycle
//             reload              - one-cycle request to restart the load
//             mem_we/addr/wdata   - instruction-memory write port (byte addr)
//             core_run            - 1 releases the core from reset
//             done                - load complete
//             error               - header count exceeded memory depth
//  Revision : 1.0 - initial release
// ============================================================================
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W+1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              core_run,
    output logic              done,
    output logic              error
);

    state_t             r_state;
    state_t             w_next;

    logic [WORD_W-1:0]  r_count;
    logic [ADDR_W-1:0]  r_index;
    logic               r_we;
    logic [ADDR_W+1:0]  r_addr;
    logic [WORD_W-1:0]  r_wdata;
    logic               r_core_run;

    logic               w_byte_en;
    logic [WORD_W-1:0]  w_word;
    logic               w_word_valid;
    logic               w_count_zero;
    logic               w_count_big;
    logic               w_last;

    // ------------------------------------------------------------------
    // Byte handshake. A reload in the same cycle wins over the byte.
    // ------------------------------------------------------------------
    assign byte_ready = ((r_state == LEN) || (r_state == DATA)) && !reload;
    assign w_byte_en  = byte_valid && byte_ready;

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (reload),
        .byte_en    (w_byte_en),
        .byte_data  (byte_data),
        .word       (w_word),
        .word_valid (w_word_valid)
    );

    // Header decode, evaluated against the freshly assembled word.
    assign w_count_zero = (w_word == '0);
    assign w_count_big  = count_exceeds(w_word, ADDR_W);

    // The index is at most DEPTH-1, so widening it to the count width and
    // comparing with count-1 identifies the final word without wrap risk.
    assign w_last = ({{(WORD_W-ADDR_W){1'b0}}, r_index} == (r_count - 32'd1));

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LEN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (reload) begin
            w_next = LEN;
        end else begin
            case (r_state)
                LEN: begin
                    if (w_word_valid) begin
                        if (w_count_zero) begin
                            w_next = DONE;
                        end else if (w_count_big) begin
                            w_next = ERR;
                        end else begin
                            w_next = DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_word_valid && w_last) begin
                        w_next = DONE;
                    end
                end
                DONE:    w_next = DONE;
                ERR:     w_next = ERR;
                default: w_next = LEN;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Count, index and memory write port. The write port registers keep
    // the last address/data after the strobe, including across reload.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_index    <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_core_run <= 1'b0;
        end else if (reload) begin
            r_count    <= '0;
            r_index    <= '0;
            r_we       <= 1'b0;
            r_core_run <= 1'b0;
        end else begin
            r_we       <= 1'b0;
            // Releasing the core one cycle after done gives the final
            // memory write a full cycle to land before fetch begins.
            r_core_run <= (r_state == DONE);
            case (r_state)
                LEN: begin
                    if (w_word_valid) begin
                        r_count <= w_word;
                        r_index <= '0;
                    end
                end
                DATA: begin
                    if (w_word_valid) begin
                        r_we    <= 1'b1;
                        r_addr  <= {r_index, 2'b00};
                        r_wdata <= w_word;
                        // Hold the index on the final word so it never wraps.
                        if (!w_last) begin
                            r_index <= r_index + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign core_run  = r_core_run;
    assign done      = (r_state == DONE);
    assign error     = (r_state == ERR);

endmodule : instr_loader
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_loader
//  Purpose  : Self-checking bench for instr_loader (ADDR_W=4, DEPTH=16).
//             A byte-queue reference model predicts every output each cycle;
//             an expected-write queue and literal checks pin known cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_loader;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              reload;
    logic              mem_we;
    logic [ADDR_W+1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_run;
    logic              done;
    logic              error;

    always #5 clk = ~clk;

    instr_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .reload     (reload),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_run   (core_run),
        .done       (done),
        .error      (error)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: bytes accepted go into a queue; four bytes form a
    // word which takes effect one edge later (header or memory write).
    // Phases: 0 header, 1 data, 2 done, 3 error.
    // ------------------------------------------------------------------
    int          m_phase = 0;
    logic [7:0]  m_q[$];
    bit          m_pend  = 0;
    logic [31:0] m_pword = '0;
    logic [31:0] m_cnt   = '0;
    int          m_idx   = 0;
    logic        m_we    = 1'b0;
    logic [ADDR_W+1:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic        m_core  = 1'b0;
    bit          model_on = 0;

    always @(posedge clk) begin : model
        bit acc;
        acc = byte_valid && (m_phase < 2) && !reload;
        if (rst) begin
            m_phase = 0; m_q.delete(); m_pend = 0; m_cnt = '0; m_idx = 0;
            m_we = 1'b0; m_addr = '0; m_wdata = '0; m_core = 1'b0;
        end else if (reload) begin
            m_phase = 0; m_q.delete(); m_pend = 0; m_cnt = '0; m_idx = 0;
            m_we = 1'b0; m_core = 1'b0;
        end else begin
            m_core = (m_phase == 2);
            m_we   = 1'b0;
            if (m_pend) begin
                if (m_phase == 0) begin
                    m_cnt = m_pword;
                    m_idx = 0;
                    if (m_cnt == 0)                m_phase = 2;
                    else if (m_cnt > 32'(DEPTH))   m_phase = 3;
                    else                           m_phase = 1;
                end else if (m_phase == 1) begin
                    m_we    = 1'b1;
                    m_addr  = (ADDR_W+2)'(m_idx * 4);
                    m_wdata = m_pword;
                    if (m_idx == int'(m_cnt) - 1) m_phase = 2;
                    else                          m_idx++;
                end
            end
            m_pend = 0;
            if (acc) begin
                m_q.push_back(byte_data);
                if (m_q.size() == 4) begin
                    m_pword = {m_q[3], m_q[2], m_q[1], m_q[0]};
                    m_pend  = 1;
                    m_q.delete();
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare process + write log + expected-write scoreboard
    // ------------------------------------------------------------------
    int          cyc = 0;
    logic [ADDR_W+1:0] wlog_addr[$];
    logic [31:0] wlog_data[$];
    int          wlog_cyc[$];
    logic [ADDR_W+1:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          done_cyc = -1;
    int          core_cyc = -1;
    logic        prev_done = 1'b0;
    logic        prev_core = 1'b0;

    always @(negedge clk) begin
        if (model_on) begin
            cyc++;
            check("mem_we",     mem_we,     m_we);
            check("mem_addr",   mem_addr,   m_addr);
            check("mem_wdata",  mem_wdata,  m_wdata);
            check("done",       done,       m_phase == 2);
            check("error",      error,      m_phase == 3);
            check("core_run",   core_run,   m_core);
            check("byte_ready", byte_ready, (m_phase < 2) && !reload);
            if (mem_we) begin
                wlog_addr.push_back(mem_addr);
                wlog_data.push_back(mem_wdata);
                wlog_cyc.push_back(cyc);
                if (exp_addr.size() == 0) begin
                    check("unexpected write", 1'b1, 1'b0);
                end else begin
                    check("sb addr", mem_addr,  exp_addr.pop_front());
                    check("sb data", mem_wdata, exp_data.pop_front());
                end
            end
            if (done && !prev_done)     done_cyc = cyc;
            if (core_run && !prev_core) core_cyc = cyc;
            prev_done = done;
            prev_core = core_run;
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int  gap;
        bit  ok;
        gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
        byte_valid = 1'b0;
        repeat (gap) begin
            byte_data = 8'($urandom);
            tick();
        end
        byte_valid = 1'b1;
        byte_data  = b;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = byte_ready;
            tick();
        end
        byte_valid = 1'b0;
        if (!ok) check("byte accept timeout", 1'b0, 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], maxgap);
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    task automatic clear_logs();
        wlog_addr.delete(); wlog_data.delete(); wlog_cyc.delete();
        done_cyc = -1; core_cyc = -1;
    endtask

    task automatic expect_write(input int idx, input logic [31:0] d);
        exp_addr.push_back((ADDR_W+2)'(idx * 4));
        exp_data.push_back(d);
    endtask

    task automatic wait_end(input int budget);
        bit hit;
        hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            hit = done || error;
        end
        if (!hit) check("done/error timeout", 1'b0, 1'b1);
        repeat (2) tick();
    endtask

    logic [31:0] gen[$];

    task automatic load(input int n, input int maxgap);
        logic [31:0] w;
        do_reload();
        clear_logs();
        gen.delete();
        send_word(32'(n), maxgap);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            gen.push_back(w);
            expect_write(i, w);
            send_word(w, maxgap);
        end
        wait_end(200);
        check("load done", done, 1'b1);
        check("load writes", wlog_addr.size(), n);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] w0;
        bit          seen;
        rst = 1'b1; byte_valid = 1'b0; byte_data = '0; reload = 1'b0;
        repeat (3) tick();
        model_on = 1;
        @(negedge clk);
        check("reset mem_we",    mem_we,    1'b0);
        check("reset mem_addr",  mem_addr,  '0);
        check("reset mem_wdata", mem_wdata, '0);
        check("reset done",      done,      1'b0);
        check("reset error",     error,     1'b0);
        check("reset core_run",  core_run,  1'b0);
        tick();
        rst = 1'b0;
        tick();

        // 1: two-word gapless load with known contents
        clear_logs();
        expect_write(0, 32'h0010_0013);
        expect_write(1, 32'h0020_0093);
        send_word(32'h0000_0002, 0);
        send_word(32'h0010_0013, 0);
        send_word(32'h0020_0093, 0);
        wait_end(50);
        check("t1 writes", wlog_addr.size(), 2);
        if (wlog_addr.size() == 2) begin
            check("t1 addr0", wlog_addr[0], 6'h00);
            check("t1 data0", wlog_data[0], 32'h0010_0013);
            check("t1 addr1", wlog_addr[1], 6'h04);
            check("t1 data1", wlog_data[1], 32'h0020_0093);
            check("t1 done with last write", done_cyc, wlog_cyc[1]);
        end
        check("t1 core_run after done", core_cyc, done_cyc + 1);

        // 2: zero-length image
        do_reload();
        clear_logs();
        send_word(32'h0, 0);
        wait_end(50);
        @(negedge clk);
        check("t2 writes", wlog_addr.size(), 0);
        check("t2 done", done, 1'b1);
        check("t2 byte_ready", byte_ready, 1'b0);
        check("t2 core_run", core_run, 1'b1);
        check("t2 core_run after done", core_cyc, done_cyc + 1);

        // 3: count 17 exceeds DEPTH=16, then recover with reload
        do_reload();
        clear_logs();
        send_word(32'h11, 0);
        wait_end(50);
        repeat (3) tick();
        @(negedge clk);
        check("t3 error", error, 1'b1);
        check("t3 byte_ready", byte_ready, 1'b0);
        check("t3 core_run", core_run, 1'b0);
        check("t3 writes", wlog_addr.size(), 0);
        tick();
        do_reload();
        @(negedge clk);
        check("t3 error cleared", error, 1'b0);
        check("t3 ready again", byte_ready, 1'b1);
        tick();

        // 4: three words with random 0-3 cycle bubbles
        load(3, 3);
        if (wlog_addr.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("t4 addr", wlog_addr[i], (ADDR_W+2)'(i * 4));
                check("t4 data", wlog_data[i], gen[i]);
            end
        end

        // 5: partial word dropped by reload, then a one-word load
        do_reload();
        send_word(32'h2, 0);
        send_byte(8'hAA, 0);
        send_byte(8'h55, 0);
        do_reload();
        clear_logs();
        expect_write(0, 32'hDEAD_BEEF);
        send_word(32'h1, 0);
        send_word(32'hDEAD_BEEF, 0);
        wait_end(50);
        check("t5 writes", wlog_addr.size(), 1);
        if (wlog_addr.size() == 1) begin
            check("t5 addr", wlog_addr[0], 6'h00);
            check("t5 data", wlog_data[0], 32'hDEAD_BEEF);
        end
        check("t5 done", done, 1'b1);

        // 6: reset in the middle of the data phase
        do_reload();
        clear_logs();
        w0 = $urandom;
        expect_write(0, w0);
        send_word(32'h2, 0);
        send_word(w0, 1);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = (wlog_addr.size() == 1);
        end
        if (!seen) check("t6 first write timeout", 1'b0, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("t6 mem_we",    mem_we,    1'b0);
        check("t6 mem_addr",  mem_addr,  '0);
        check("t6 mem_wdata", mem_wdata, '0);
        check("t6 done",      done,      1'b0);
        check("t6 core_run",  core_run,  1'b0);
        check("t6 ready",     byte_ready, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        load(2, 1);

        // Random loads, including the full-depth boundary
        for (int k = 0; k < 6; k++) begin
            load((k == 0) ? DEPTH : int'($urandom_range(1, DEPTH)), int'($urandom_range(0, 2)));
        end
        if (wlog_addr.size() > 0) check("last addr boundary", wlog_addr[wlog_addr.size()-1] <= 6'(4*(DEPTH-1)), 1'b1);

        // Random oversize headers
        for (int k = 0; k < 3; k++) begin
            do_reload();
            clear_logs();
            send_word(32'(DEPTH + 1) + $urandom_range(0, 100000), 1);
            wait_end(50);
            check("oversize error", error, 1'b1);
        end

        do_reload();
        repeat (3) tick();
        check("expected writes drained", exp_addr.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_instr_loader
`default_nettype wire
